// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the boot-time instruction loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_e;

   localparam int LEN_W          = 16;
   localparam int BYTES_PER_WORD = 4;
   localparam int CSUM_W         = 8;
   localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

   function automatic logic is_recv(input state_e s);
      return s inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
   endfunction

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles little-endian bytes into 32-bit words.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word_data
);

   logic [BCNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]       sr_q, sr_d;

   // First byte lands in the low lane once all four are shifted in.
   always_comb begin
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      word_data  = {byte_data, sr_q[31:8]};
      word_valid = byte_en && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
      if (clr) begin
         cnt_d = '0;
         sr_d  = '0;
      end else if (byte_en) begin
         cnt_d = cnt_q + 1'b1;
         sr_d  = word_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         sr_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sr_q  <= sr_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed image into instruction memory.
// Trailing checksum byte is enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        byte_data,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              error
);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              rdy_q, rdy_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              core_rst_q, core_rst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
`ifdef IMEM_LOADER_CSUM_EN
   logic [CSUM_W-1:0] csum_q, csum_d;
`endif

   logic             xfer, clr, fin, pk_en, word_valid;
   logic [31:0]      word_data;
   logic [LEN_W-1:0] n;

   imem_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .byte_en    (pk_en),
      .byte_data  (byte_data),
      .word_valid (word_valid),
      .word_data  (word_data)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = done_q;
      error_d   = error_q;
`ifdef IMEM_LOADER_CSUM_EN
      csum_d    = csum_q;
`endif
      xfer  = byte_valid && rdy_q;
      pk_en = xfer && (state_q == S_DATA);
      clr   = 1'b0;
      fin   = 1'b0;
      n     = {byte_data, len_q[7:0]};
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN_LO;
               done_d  = 1'b0;
               error_d = 1'b0;
               cnt_d   = '0;
               clr     = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = byte_data;
               state_d    = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d = n;
               if (int'(n) > DEPTH_WORDS) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end else if (n == '0) begin
                  fin = 1'b1;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
            if (xfer) csum_d = csum_q + byte_data;
`endif
            if (word_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q[ADDR_W-1:0];
               wr_data_d = word_data;
               cnt_d     = cnt_q + 1'b1;
               fin       = (cnt_q == len_q - 1'b1);
            end
         end
`ifdef IMEM_LOADER_CSUM_EN
         S_CSUM: begin
            if (xfer) begin
               if (byte_data == csum_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
      if (fin) begin
`ifdef IMEM_LOADER_CSUM_EN
         state_d = S_CSUM;
`else
         state_d = S_DONE;
         done_d  = 1'b1;
`endif
      end
      rdy_d      = is_recv(state_d);
      busy_d     = is_recv(state_d);
      // Lags DONE by a cycle so the last write lands before the first fetch.
      core_rst_d = (state_q != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         cnt_q      <= '0;
         rdy_q      <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         core_rst_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         rdy_q      <= rdy_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         core_rst_q <= core_rst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign byte_ready = rdy_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign core_rst   = core_rst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory from a byte stream, acting as the writer side of the core's instruction-fetch memory.
- Accepts a length-prefixed, little-endian byte stream over a valid/ready handshake.
- Packs the bytes into 32-bit words and issues one write per word at consecutive word addresses starting at 0.
- Holds the core in reset until the image has been fully written.

## Interface
Parameters:
- DEPTH_WORDS, 1024: instruction memory depth in words.
- ADDR_W, 10: word-address width. Must satisfy 2^ADDR_W >= DEPTH_WORDS.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  begin a load. Sampled only in IDLE, DONE or ERR.
- byte_data  in  8  stream byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  32  word to write.
- core_rst  out  1  reset to the core (PC, register file, data memory).
- busy  out  1  a load is in progress.
- done  out  1  load completed successfully. Sticky.
- error  out  1  load aborted. Sticky.

## Operation
- Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
  - byte_ready is high only in LEN_LO, LEN_HI, DATA and CSUM.
  - Bytes offered in any other state are not consumed.
- Stream format: N[7:0], N[15:8], then 4*N data bytes. Each word is sent least-significant byte first.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR with start=1 -> LEN_LO.
  - Clears done, error, the word counter and the checksum.
- LEN_LO: on transfer, latch the low byte of N -> LEN_HI.
- LEN_HI: on transfer, latch the high byte of N, then:
  - N > DEPTH_WORDS -> ERR.
  - N == 0 -> DONE (or CSUM if the checksum feature is compiled in).
  - Otherwise -> DATA.
- DATA: a 2-bit byte counter shifts each accepted byte into the word.
  - On the 4th byte: register wr_data, wr_addr = word index, pulse wr_en, increment the word index.
  - After word N-1 -> DONE (or CSUM).
- Word index never wraps, because N <= DEPTH_WORDS is enforced in LEN_HI.
- Stall: byte_valid low in any receive state leaves all state unchanged. There is no timeout.
- start while busy is ignored.
- core_rst is high in every state except DONE.
- A start issued from DONE reasserts core_rst on the next cycle; the core is reloaded.
- Reset mid-load: the FSM returns to IDLE and no further writes occur. Words already written remain in memory.

## Timing
- Reset values: state IDLE, byte_ready 0, wr_en 0, wr_addr 0, wr_data 0, core_rst 1, busy 0, done 0, error 0.
- busy = state in {LEN_LO, LEN_HI, DATA, CSUM}, registered.
- wr_en is high exactly one cycle, starting the cycle after the 4th byte handshake of a word.
  - wr_addr and wr_data are valid in that same cycle.
  - Back-to-back words produce at most one wr_en per 4 accepted bytes.
- done rises in the same cycle as the final wr_en (no checksum).
- core_rst falls one cycle after done rises. The final write therefore lands before the core's first fetch.
- error rises one cycle after the offending handshake.
- Minimum load time is 2 + 4*N accepted bytes, plus 1 byte with the checksum feature.

## Configuration
- IMEM_LOADER_CSUM_EN defined:
  - A trailing checksum byte follows the data. The expected value is the 8-bit modulo-256 sum of all data bytes; the length bytes are excluded.
  - In CSUM, match -> DONE, mismatch -> ERR.
  - Words written before a mismatch stay in memory, but core_rst stays high.
- IMEM_LOADER_CSUM_EN undefined:
  - The CSUM state and the checksum accumulator are absent.
  - The last data word goes directly to DONE.

## Structure
- Package imem_loader_pkg:
  - State enum.
  - Length field width (16).
  - Bytes per word (4).
  - Checksum width (8).
- One sub-module, imem_word_packer: a byte counter and shift register that outputs word_valid with the assembled 32-bit word.
- The FSM, address counter and checksum stay in imem_loader.

## Test plan
- Nominal load: start, stream 01 00 33 E2 62 00 -> one wr_en with wr_addr=0, wr_data=32'h0062E233; done=1 the same cycle; core_rst=0 the next cycle.
- Oversize: N=1025 (bytes 01 04) with DEPTH_WORDS=1024 -> ERR; error=1, no wr_en, core_rst stays 1.
- Empty image: N=0 -> done after the 2nd byte, no wr_en.
- Throttling: 3 words sent with byte_valid toggling every cycle -> wr_addr 0,1,2 in order, data intact, no extra writes.
- Reset mid-load: rst during word 2 of 4 -> only addresses 0 and 1 written; IDLE; core_rst=1; a subsequent full load succeeds.
- Checksum (IMEM_LOADER_CSUM_EN): one word 11 22 33 44 with trailer 0xAA -> done; the same word with trailer 0xAB -> error=1 and core_rst=1.
